// File: rtl/jtag_tap_bsr.sv
// IEEE 1149.1-style TAP controller with instruction register, bypass, IDCODE
// and a boundary scan register with separate shift and update stages.
module jtag_tap_bsr #(
   parameter int unsigned IR_WIDTH   = 4,
   parameter int unsigned BSR_LEN    = 268,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0A5B
) (
   input  logic                TCK,
   input  logic                reset,
   input  logic                TMS,
   input  logic                TDI,
   output logic                TDO,
   output logic                tdo_en,
   input  logic [BSR_LEN-1:0]  bsr_pin_in,
   output logic [BSR_LEN-1:0]  bsr_pin_out,
   output logic                bsr_mode,
   output logic [IR_WIDTH-1:0] ir_out,
   output logic [3:0]          tap_state
);

   localparam int unsigned ID_W = 32;

   localparam logic [IR_WIDTH-1:0] INS_EXTEST = '0;
   localparam logic [IR_WIDTH-1:0] INS_SAMPLE = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] INS_IDCODE = IR_WIDTH'(2);

   typedef enum logic [3:0] {
      TLR     = 4'hF,
      RTI     = 4'hC,
      SEL_DR  = 4'h7,
      CAP_DR  = 4'h6,
      SH_DR   = 4'h2,
      EX1_DR  = 4'h1,
      PAU_DR  = 4'h3,
      EX2_DR  = 4'h0,
      UPD_DR  = 4'h5,
      SEL_IR  = 4'h4,
      CAP_IR  = 4'hE,
      SH_IR   = 4'hA,
      EX1_IR  = 4'h9,
      PAU_IR  = 4'hB,
      EX2_IR  = 4'h8,
      UPD_IR  = 4'hD
   } tap_state_e;

   tap_state_e          state_q, state_d;
   logic [IR_WIDTH-1:0] ir_q, ir_d;
   logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
   logic [BSR_LEN-1:0]  bsr_sr_q, bsr_sr_d;
   logic [BSR_LEN-1:0]  bsr_upd_q, bsr_upd_d;
   logic [ID_W-1:0]     id_sr_q, id_sr_d;
   logic                byp_q, byp_d;
   logic                bsr_mode_q, bsr_mode_d;
   logic                sel_bsr, sel_id;

   // Unknown codes (including all-ones) fall through to bypass.
   assign sel_bsr = (ir_q == INS_EXTEST) || (ir_q == INS_SAMPLE);
   assign sel_id  = (ir_q == INS_IDCODE);

   // TAP state register
   always_ff @(posedge TCK) begin
      if (reset) state_q <= TLR;
      else       state_q <= state_d;
   end

   // TAP next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:    state_d = TMS ? TLR    : RTI;
         RTI:    state_d = TMS ? SEL_DR : RTI;
         SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
         CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
         SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
         EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
         PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
         EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
         UPD_DR: state_d = TMS ? SEL_DR : RTI;
         SEL_IR: state_d = TMS ? TLR    : CAP_IR;
         CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
         SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
         EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
         PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
         EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
         UPD_IR: state_d = TMS ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   // Register actions keyed on the current state
   always_comb begin
      ir_d       = ir_q;
      ir_sr_d    = ir_sr_q;
      bsr_sr_d   = bsr_sr_q;
      bsr_upd_d  = bsr_upd_q;
      id_sr_d    = id_sr_q;
      byp_d      = byp_q;
      bsr_mode_d = (ir_q == INS_EXTEST);
      case (state_q)
         CAP_IR: ir_sr_d = IR_WIDTH'(1);
         SH_IR:  ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
         UPD_IR: ir_d    = ir_sr_q;
         CAP_DR: begin
            if (sel_bsr)     bsr_sr_d = bsr_pin_in;
            else if (sel_id) id_sr_d  = IDCODE_VAL;
            else             byp_d    = 1'b0;
         end
         SH_DR: begin
            // Shift form stays legal when BSR_LEN is 1.
            if (sel_bsr)     bsr_sr_d = (bsr_sr_q >> 1) | (BSR_LEN'(TDI) << (BSR_LEN - 1));
            else if (sel_id) id_sr_d  = {TDI, id_sr_q[ID_W-1:1]};
            else             byp_d    = TDI;
         end
         UPD_DR: if (sel_bsr) bsr_upd_d = bsr_sr_q;
         default: ;
      endcase
      // Arriving in Test-Logic-Reset restores the power-on instruction.
      if (state_d == TLR) begin
         ir_d       = INS_IDCODE;
         bsr_mode_d = 1'b0;
      end
   end

   always_ff @(posedge TCK) begin
      if (reset) begin
         ir_q       <= INS_IDCODE;
         ir_sr_q    <= '0;
         bsr_sr_q   <= '0;
         bsr_upd_q  <= '0;
         id_sr_q    <= '0;
         byp_q      <= 1'b0;
         bsr_mode_q <= 1'b0;
      end else begin
         ir_q       <= ir_d;
         ir_sr_q    <= ir_sr_d;
         bsr_sr_q   <= bsr_sr_d;
         bsr_upd_q  <= bsr_upd_d;
         id_sr_q    <= id_sr_d;
         byp_q      <= byp_d;
         bsr_mode_q <= bsr_mode_d;
      end
   end

   // TDO follows the active shift path directly from the state register.
   always_comb begin
      TDO = 1'b0;
      case (state_q)
         SH_IR: TDO = ir_sr_q[0];
         SH_DR: begin
            if (sel_bsr)     TDO = bsr_sr_q[0];
            else if (sel_id) TDO = id_sr_q[0];
            else             TDO = byp_q;
         end
         default: ;
      endcase
   end

   assign tdo_en      = (state_q == SH_IR) || (state_q == SH_DR);
   assign bsr_pin_out = bsr_upd_q;
   assign bsr_mode    = bsr_mode_q;
   assign ir_out      = ir_q;
   assign tap_state   = state_q;

endmodule

// File: tb/tb_jtag_tap_bsr.sv
// Self-checking bench for jtag_tap_bsr: directed scenarios plus random TMS/TDI
// traffic compared against a table-driven TAP reference model.
module tb_jtag_tap_bsr;

   localparam int unsigned IR_W   = 4;
   localparam int unsigned BSR_N  = 268;
   localparam logic [31:0] ID_VAL = 32'h1000_0A5B;

   // Next state indexed by state encoding, for TMS=0 and TMS=1.
   localparam logic [3:0] NS0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                                       4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
   localparam logic [3:0] NS1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                                       4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

   logic              TCK = 1'b0;
   logic              reset = 1'b0;
   logic              TMS = 1'b1;
   logic              TDI = 1'b0;
   logic              TDO, tdo_en, bsr_mode;
   logic [BSR_N-1:0]  bsr_pin_in = '0;
   logic [BSR_N-1:0]  bsr_pin_out;
   logic [IR_W-1:0]   ir_out;
   logic [3:0]        tap_state;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [3:0]       m_state = 4'hF;
   logic [IR_W-1:0]  m_ir = IR_W'(2);
   logic [IR_W-1:0]  m_irsr = '0;
   logic [BSR_N-1:0] m_bsr_sr = '0;
   logic [BSR_N-1:0] m_bsr_out = '0;
   logic [31:0]      m_id = '0;
   logic             m_byp = 1'b0;
   logic             m_mode = 1'b0;

   jtag_tap_bsr #(.IR_WIDTH(IR_W), .BSR_LEN(BSR_N), .IDCODE_VAL(ID_VAL)) dut (
      .TCK(TCK), .reset(reset), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
      .bsr_pin_in(bsr_pin_in), .bsr_pin_out(bsr_pin_out), .bsr_mode(bsr_mode),
      .ir_out(ir_out), .tap_state(tap_state)
   );

   always #5 TCK = ~TCK;

   // 0 = boundary scan, 1 = IDCODE, 2 = bypass
   function automatic int m_sel();
      if (m_ir == 0 || m_ir == 1) return 0;
      if (m_ir == 2) return 1;
      return 2;
   endfunction

   function automatic logic m_tdo();
      if (m_state == 4'hA) return m_irsr[0];
      if (m_state == 4'h2) begin
         case (m_sel())
            0: return m_bsr_sr[0];
            1: return m_id[0];
            default: return m_byp;
         endcase
      end
      return 1'b0;
   endfunction

   task automatic model_edge(input logic tms, input logic tdi);
      logic [3:0] nxt;
      logic       mode_n;
      int         s;
      if (reset) begin
         m_state = 4'hF; m_ir = IR_W'(2); m_irsr = '0; m_bsr_sr = '0;
         m_bsr_out = '0; m_id = '0; m_byp = 1'b0; m_mode = 1'b0;
      end else begin
         s      = m_sel();
         mode_n = (m_ir == 0);
         nxt    = tms ? NS1[m_state] : NS0[m_state];
         case (m_state)
            4'hE: m_irsr = IR_W'(1);
            4'hA: m_irsr = (m_irsr >> 1) | (IR_W'(tdi) << (IR_W - 1));
            4'hD: m_ir = m_irsr;
            4'h6: begin
               if (s == 0)      m_bsr_sr = bsr_pin_in;
               else if (s == 1) m_id = ID_VAL;
               else             m_byp = 1'b0;
            end
            4'h2: begin
               if (s == 0)      m_bsr_sr = (m_bsr_sr >> 1) | (BSR_N'(tdi) << (BSR_N - 1));
               else if (s == 1) m_id = (m_id >> 1) | (32'(tdi) << 31);
               else             m_byp = tdi;
            end
            4'h5: if (s == 0) m_bsr_out = m_bsr_sr;
            default: ;
         endcase
         if (nxt == 4'hF) begin
            m_ir   = IR_W'(2);
            mode_n = 1'b0;
         end
         m_mode  = mode_n;
         m_state = nxt;
      end
   endtask

   // One TCK cycle: drive at negedge, sample TDO before the rising edge.
   task automatic step(input logic tms, input logic tdi, output logic tdo_o, output logic tdo_x);
      @(negedge TCK);
      TMS = tms;
      TDI = tdi;
      #1;
      tdo_o = TDO;
      tdo_x = m_tdo();
      model_edge(tms, tdi);
      @(posedge TCK);
      #1;
   endtask

   task automatic go(input logic tms);
      logic o, x;
      step(tms, 1'b0, o, x);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      go(1'b0);
      reset = 1'b0;
   endtask

   // From RTI: load an instruction and return to RTI.
   task automatic load_ir(input logic [IR_W-1:0] code);
      logic o, x;
      go(1); go(1); go(0); go(0);
      for (int i = 0; i < int'(IR_W); i++) step((i == int'(IR_W) - 1), code[i], o, x);
      go(1); go(0);
   endtask

   // From RTI: scan n DR bits (LSB first), collect TDO, return to RTI.
   task automatic scan_dr(input int n, input logic [BSR_N-1:0] din, output logic [BSR_N-1:0] dout);
      logic o, x;
      dout = '0;
      go(1); go(0); go(0);
      for (int i = 0; i < n; i++) begin
         step((i == n - 1), din[i], o, x);
         dout[i] = o;
      end
      go(1); go(0);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (tap_state !== 4'hF) $display("FAIL reset_state got=%h exp=f", tap_state); else n_pass++;
      n_checks++;
      if (ir_out !== IR_W'(2)) $display("FAIL reset_ir got=%h exp=2", ir_out); else n_pass++;
      n_checks++;
      if ({TDO, tdo_en, bsr_mode} !== 3'b000)
         $display("FAIL reset_outs got=%b%b%b exp=000", TDO, tdo_en, bsr_mode);
      else n_pass++;
      n_checks++;
      if (bsr_pin_out !== '0) $display("FAIL reset_pins got=%h exp=0", bsr_pin_out); else n_pass++;
      go(0);
      n_checks++;
      if (tap_state !== 4'hC || ir_out !== IR_W'(2) || bsr_mode !== 1'b0)
         $display("FAIL reset_to_rti got=%h/%h/%b exp=c/2/0", tap_state, ir_out, bsr_mode);
      else n_pass++;
   endtask

   task automatic test_tlr5();
      for (int i = 0; i < 5; i++) go(1);
      n_checks++;
      if (tap_state !== 4'hF) $display("FAIL tlr5_rti got=%h exp=f", tap_state); else n_pass++;
      go(0); go(1); go(0); go(0);
      n_checks++;
      if (tap_state !== 4'h2) $display("FAIL tlr5_reach_shdr got=%h exp=2", tap_state); else n_pass++;
      for (int i = 0; i < 4; i++) go(1);
      n_checks++;
      if (tap_state !== 4'h4) $display("FAIL tlr5_shdr_4th got=%h exp=4", tap_state); else n_pass++;
      go(1);
      n_checks++;
      if (tap_state !== 4'hF) $display("FAIL tlr5_shdr got=%h exp=f", tap_state); else n_pass++;
      go(0); go(1); go(1); go(0); go(0); go(1); go(0);
      n_checks++;
      if (tap_state !== 4'hB) $display("FAIL tlr5_reach_pauseir got=%h exp=b", tap_state); else n_pass++;
      for (int i = 0; i < 4; i++) go(1);
      n_checks++;
      if (tap_state !== 4'h4) $display("FAIL tlr5_pauseir_4th got=%h exp=4", tap_state); else n_pass++;
      go(1);
      n_checks++;
      if (tap_state !== 4'hF || ir_out !== IR_W'(2))
         $display("FAIL tlr5_pauseir got=%h/%h exp=f/2", tap_state, ir_out);
      else n_pass++;
      go(0);
   endtask

   task automatic test_ir_bypass();
      logic [IR_W-1:0]  obs;
      logic [BSR_N-1:0] din, dout;
      logic             o, x;
      go(1); go(1); go(0); go(0);
      for (int i = 0; i < int'(IR_W); i++) begin
         step((i == int'(IR_W) - 1), 1'b1, o, x);
         obs[i] = o;
      end
      go(1); go(0);
      n_checks++;
      if (obs !== IR_W'(1)) $display("FAIL ir_capture_tdo got=%b exp=%b", obs, IR_W'(1)); else n_pass++;
      n_checks++;
      if (ir_out !== '1) $display("FAIL ir_update got=%h exp=all ones", ir_out); else n_pass++;
      din = '0;
      din[0] = 1'b1;
      din[2] = 1'b1;
      scan_dr(3, din, dout);
      n_checks++;
      if (dout[2:0] !== 3'b010) $display("FAIL bypass_delay got=%b exp=010", dout[2:0]); else n_pass++;
   endtask

   task automatic test_idcode();
      logic [BSR_N-1:0] dout;
      do_reset();
      go(0);
      scan_dr(32, '0, dout);
      n_checks++;
      if (dout[31:0] !== ID_VAL) $display("FAIL idcode got=%h exp=%h", dout[31:0], ID_VAL); else n_pass++;
   endtask

   task automatic test_sample_extest();
      logic [BSR_N-1:0] pat, dout;
      for (int i = 0; i < int'(BSR_N); i++) pat[i] = (i % 2 == 0);
      bsr_pin_in = pat;
      load_ir(IR_W'(1));
      scan_dr(BSR_N, '1, dout);
      n_checks++;
      if (dout !== pat) $display("FAIL sample_capture got=%h exp=%h", dout, pat); else n_pass++;
      n_checks++;
      if (bsr_pin_out !== '1) $display("FAIL preload_update got=%h exp=all ones", bsr_pin_out); else n_pass++;
      n_checks++;
      if (bsr_mode !== 1'b0) $display("FAIL sample_mode got=%b exp=0", bsr_mode); else n_pass++;
      load_ir(IR_W'(0));
      n_checks++;
      if (bsr_mode !== 1'b0 || ir_out !== IR_W'(0))
         $display("FAIL extest_at_upd got=%b/%h exp=0/0", bsr_mode, ir_out);
      else n_pass++;
      go(0);
      n_checks++;
      if (bsr_mode !== 1'b1) $display("FAIL extest_mode got=%b exp=1", bsr_mode); else n_pass++;
      n_checks++;
      if (bsr_pin_out !== '1) $display("FAIL extest_pins_hold got=%h exp=all ones", bsr_pin_out); else n_pass++;
   endtask

   task automatic test_pause_resume();
      logic [31:0] obs;
      logic        o, x;
      do_reset();
      go(0); go(1); go(0); go(0);
      for (int i = 0; i < 10; i++) begin
         step((i == 9), 1'b0, o, x);
         obs[i] = o;
      end
      go(0); go(0); go(0);
      n_checks++;
      if (tap_state !== 4'h3 || tdo_en !== 1'b0)
         $display("FAIL pause_state got=%h/%b exp=3/0", tap_state, tdo_en);
      else n_pass++;
      go(1); go(0);
      for (int i = 10; i < 32; i++) begin
         step((i == 31), 1'b0, o, x);
         obs[i] = o;
      end
      go(1); go(0);
      n_checks++;
      if (obs !== ID_VAL) $display("FAIL pause_resume got=%h exp=%h", obs, ID_VAL); else n_pass++;
   endtask

   task automatic test_reset_mid_shir();
      logic o, x;
      load_ir('1);
      go(1); go(1); go(0); go(0);
      step(1'b0, 1'b0, o, x);
      step(1'b0, 1'b0, o, x);
      n_checks++;
      if (tap_state !== 4'hA || tdo_en !== 1'b1)
         $display("FAIL mid_shir_state got=%h/%b exp=a/1", tap_state, tdo_en);
      else n_pass++;
      do_reset();
      n_checks++;
      if (tap_state !== 4'hF || ir_out !== IR_W'(2))
         $display("FAIL mid_shir_reset got=%h/%h exp=f/2", tap_state, ir_out);
      else n_pass++;
   endtask

   task automatic test_random();
      logic o, x, tms, tdi;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 15) == 0)
            for (int i = 0; i < int'(BSR_N); i++) bsr_pin_in[i] = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 299) == 0);
         tms   = ($urandom_range(0, 3) == 0);
         tdi   = 1'($urandom_range(0, 1));
         step(tms, tdi, o, x);
         reset = 1'b0;
         n_checks++;
         if (o !== x) $display("FAIL rnd_tdo cyc=%0d got=%b exp=%b", c, o, x); else n_pass++;
         n_checks++;
         if (tap_state !== m_state || tdo_en !== (m_state == 4'hA || m_state == 4'h2))
            $display("FAIL rnd_state cyc=%0d got=%h/%b exp=%h", c, tap_state, tdo_en, m_state);
         else n_pass++;
         n_checks++;
         if (ir_out !== m_ir || bsr_mode !== m_mode)
            $display("FAIL rnd_ir cyc=%0d got=%h/%b exp=%h/%b", c, ir_out, bsr_mode, m_ir, m_mode);
         else n_pass++;
         n_checks++;
         if (bsr_pin_out !== m_bsr_out)
            $display("FAIL rnd_pins cyc=%0d got=%h exp=%h", c, bsr_pin_out, m_bsr_out);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_tlr5();
      test_ir_bypass();
      test_idcode();
      test_sample_extest();
      test_pause_resume();
      test_reset_mid_shir();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
